span_walker: RTL and testbench

- Consumer end of the triangle FIFO written by the triangle setup stage.
- Pops one 217-bit setup record and walks its scanlines top to bottom.
- For each scanline, emits one span record to the span FIFO feeding the pixel stepper. A span holds the long-edge x, the short-edge x, the long-edge z/r/g/b and the per-pixel x-step gradients.
- Throughput is one span per clock when not back-pressured.

---
 rtl/span_walker.sv | 161 ++++++++++++++++
 tb/tb_span_walker.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/span_walker.sv
// Triangle FIFO consumer: walks each setup record top to bottom and emits
// one clamped/saturated span record per scanline into the span FIFO.
module span_walker #(
  parameter int ROUND_HALF = 1,
  parameter int X_MAX      = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [216:0] tri_data,
  input  logic         tri_empty,
  output logic         tri_pull,
  output logic [130:0] span_data,
  input  logic         span_full,
  output logic         span_push
);

  typedef enum logic { S_IDLE, S_WALK } state_t;

  localparam logic [13:0] OFF   = (ROUND_HALF != 0) ? 14'd32 : 14'd0;
  localparam logic [6:0]  XMAX7 = 7'(X_MAX);

  // Incoming record fields; x3 is not needed once the slopes are known.
  logic [7:0]  w_t_cmd;
  logic [5:0]  w_t_x1, w_t_x2, w_t_y1, w_t_y2, w_t_y3;
  logic [12:0] w_t_m1, w_t_m2, w_t_m3;
  logic [9:0]  w_t_z1;
  logic [16:0] w_t_mz, w_t_nz;
  logic [4:0]  w_t_r1, w_t_b1;
  logic [11:0] w_t_mr, w_t_nr, w_t_mb, w_t_nb;
  logic [5:0]  w_t_g1;
  logic [12:0] w_t_mg, w_t_ng;
  logic        w_unused_x3;

  assign w_t_cmd     = tri_data[216:209];
  assign w_t_x1      = tri_data[208:203];
  assign w_t_x2      = tri_data[202:197];
  assign w_unused_x3 = ^tri_data[196:191];
  assign w_t_y1      = tri_data[190:185];
  assign w_t_y2      = tri_data[184:179];
  assign w_t_y3      = tri_data[178:173];
  assign w_t_m1      = tri_data[172:160];
  assign w_t_m2      = tri_data[159:147];
  assign w_t_m3      = tri_data[146:134];
  assign w_t_z1      = tri_data[133:124];
  assign w_t_mz      = tri_data[123:107];
  assign w_t_nz      = tri_data[106:90];
  assign w_t_r1      = tri_data[89:85];
  assign w_t_mr      = tri_data[84:73];
  assign w_t_nr      = tri_data[72:61];
  assign w_t_g1      = tri_data[60:55];
  assign w_t_mg      = tri_data[54:42];
  assign w_t_ng      = tri_data[41:29];
  assign w_t_b1      = tri_data[28:24];
  assign w_t_mb      = tri_data[23:12];
  assign w_t_nb      = tri_data[11:0];

  state_t      r_state, w_state_next;
  logic        w_step;
  logic [7:0]  r_cmd;
  logic [5:0]  r_x2, r_y2, r_y3, r_y;
  logic [12:0] r_m1, r_m2, r_m3, r_mg, r_ng;
  logic [16:0] r_mz, r_nz;
  logic [11:0] r_mr, r_nr, r_mb, r_nb;
  logic [13:0] r_xl, r_xs, r_g;
  logic [17:0] r_z;
  logic [12:0] r_r, r_b;
  logic        w_last, w_reload;

  function automatic logic [5:0] clampx(input logic [13:0] v);
    if (v[13])             return 6'd0;
    else if (v[12:6] > XMAX7) return XMAX7[5:0];
    else                   return v[11:6];
  endfunction

  function automatic logic [15:0] satz(input logic [17:0] v);
    if (v[17])      return 16'h0000;
    else if (v[16]) return 16'hFFFF;
    else            return v[15:0];
  endfunction

  function automatic logic [10:0] sat11(input logic [12:0] v);
    if (v[12])      return 11'h000;
    else if (v[11]) return 11'h7FF;
    else            return v[10:0];
  endfunction

  function automatic logic [11:0] satg(input logic [13:0] v);
    if (v[13])      return 12'h000;
    else if (v[12]) return 12'hFFF;
    else            return v[11:0];
  endfunction

  assign w_last   = ({1'b0, r_y} + 7'd1) == {1'b0, r_y3};
  assign w_reload = ({1'b0, r_y} + 7'd1) == {1'b0, r_y2};

  always_comb begin
    w_state_next = r_state;
    tri_pull     = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!tri_empty && rst) begin
          tri_pull     = 1'b1;
          w_state_next = S_WALK;
        end
      end
      S_WALK: begin
        if (r_y == r_y3)  w_state_next = S_IDLE;
        else if (!span_full) w_step    = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      span_push <= 1'b0;
      span_data <= '0;
      r_cmd <= '0; r_x2 <= '0; r_y2 <= '0; r_y3 <= '0; r_y <= '0;
      r_m1 <= '0; r_m2 <= '0; r_m3 <= '0;
      r_mz <= '0; r_mr <= '0; r_mg <= '0; r_mb <= '0;
      r_nz <= '0; r_nr <= '0; r_ng <= '0; r_nb <= '0;
      r_xl <= '0; r_xs <= '0; r_z <= '0; r_r <= '0; r_g <= '0; r_b <= '0;
    end else begin
      r_state   <= w_state_next;
      span_push <= w_step;
      if (tri_pull) begin
        r_cmd <= w_t_cmd; r_x2 <= w_t_x2; r_y2 <= w_t_y2; r_y3 <= w_t_y3;
        r_m1 <= w_t_m1; r_m2 <= w_t_m2; r_m3 <= w_t_m3;
        r_mz <= w_t_mz; r_mr <= w_t_mr; r_mg <= w_t_mg; r_mb <= w_t_mb;
        r_nz <= w_t_nz; r_nr <= w_t_nr; r_ng <= w_t_ng; r_nb <= w_t_nb;
        r_y  <= w_t_y1;
        r_xl <= {2'b0, w_t_x1, 6'b0} + OFF;
        // Flat top starts the short edge at v2 and never uses m2.
        r_xs <= (w_t_y1 == w_t_y2) ? ({2'b0, w_t_x2, 6'b0} + OFF)
                                   : ({2'b0, w_t_x1, 6'b0} + OFF);
        r_z  <= {2'b0, w_t_z1, 6'b0};
        r_r  <= {2'b0, w_t_r1, 6'b0};
        r_g  <= {2'b0, w_t_g1, 6'b0};
        r_b  <= {2'b0, w_t_b1, 6'b0};
      end
      if (w_step) begin
        span_data <= {r_cmd, w_last, r_y, clampx(r_xl), clampx(r_xs),
                      satz(r_z), sat11(r_r), satg(r_g), sat11(r_b),
                      r_nz, r_nr, r_ng, r_nb};
        r_y  <= r_y + 6'd1;
        r_xl <= r_xl + {r_m1[12], r_m1};
        r_z  <= r_z + {r_mz[16], r_mz};
        r_r  <= r_r + {r_mr[11], r_mr};
        r_g  <= r_g + {r_mg[12], r_mg};
        r_b  <= r_b + {r_mb[11], r_mb};
        // Snap to v2 exactly when the short edge turns the corner.
        if (w_reload)        r_xs <= {2'b0, r_x2, 6'b0} + OFF;
        else if (r_y < r_y2) r_xs <= r_xs + {r_m2[12], r_m2};
        else                 r_xs <= r_xs + {r_m3[12], r_m3};
      end
    end
  end

endmodule

// File: tb/tb_span_walker.sv
// Directed bench for span_walker: a show-ahead FIFO model feeds records,
// expected spans go into a scoreboard queue checked by an output monitor.
module tb_span_walker;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [216:0] tri_data = '0;
  logic         tri_empty = 1'b1;
  logic         tri_pull;
  logic [130:0] span_data;
  logic         span_full = 1'b0;
  logic         span_push;

  span_walker #(.ROUND_HALF(1), .X_MAX(63)) dut (
    .clk(clk), .rst(rst), .tri_data(tri_data), .tri_empty(tri_empty),
    .tri_pull(tri_pull), .span_data(span_data), .span_full(span_full),
    .span_push(span_push)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [216:0] fifo_q[$];
  logic [130:0] exp_q[$];
  int           pull_log[$];
  int           last_log[$];
  int           vec_cnt = 0;
  int           err_cnt = 0;
  int           push_cnt = 0;

  int          s1_xl[8] = '{10, 11, 13, 14, 15, 16, 18, 19};
  int          s1_xs[8] = '{10, 8, 5, 3, 0, 5, 10, 15};
  int          s4_xl[6] = '{60, 62, 63, 63, 63, 63};
  int          s4_xs[6] = '{2, 0, 0, 0, 0, 0};
  logic [15:0] s4_z[6]  = '{16'hFF00, 16'hFF80, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
  logic [10:0] s4_r[6]  = '{11'h7C0, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF};
  logic [11:0] s4_g[6]  = '{12'hFC0, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF};

  function automatic logic [216:0] mk_rec(
    input logic [7:0] cmd, input logic [5:0] x1, x2, x3, y1, y2, y3,
    input logic [12:0] m1, m2, m3,
    input logic [9:0] z1, input logic [16:0] mz, nz,
    input logic [4:0] r1, input logic [11:0] mr, nr,
    input logic [5:0] g1, input logic [12:0] mg, ng,
    input logic [4:0] b1, input logic [11:0] mb, nb);
    return {cmd, x1, x2, x3, y1, y2, y3, m1, m2, m3, z1, mz, nz,
            r1, mr, nr, g1, mg, ng, b1, mb, nb};
  endfunction

  function automatic logic [130:0] mk_span(
    input logic [7:0] cmd, input logic last, input logic [5:0] y, xl, xs,
    input logic [15:0] z, input logic [10:0] r, input logic [11:0] g,
    input logic [10:0] b, input logic [16:0] nz, input logic [11:0] nr,
    input logic [12:0] ng, input logic [11:0] nb);
    return {cmd, last, y, xl, xs, z, r, g, b, nz, nr, ng, nb};
  endfunction

  // Scenario 1 triangle: v1=(10,0) v2=(0,4) v3=(20,8); z/r/g/b ramps by
  // +1.0, +0.5, -1.0, -0.25 per row (b goes negative at once, so reads 0).
  task automatic q_s1(input logic [7:0] cmd);
    fifo_q.push_back(mk_rec(cmd, 6'd10, 6'd0, 6'd20, 6'd0, 6'd4, 6'd8,
                            13'd80, 13'h1F60, 13'd320,
                            10'd100, 17'd64, 17'h1ABCD,
                            5'd3, 12'd32, 12'h123,
                            6'd10, 13'h1FC0, 13'h1F0F,
                            5'd0, 12'hFF0, 12'hABC));
    for (int k = 0; k < 8; k++)
      exp_q.push_back(mk_span(cmd, k == 7, 6'(k), 6'(s1_xl[k]), 6'(s1_xs[k]),
                              16'((100 + k) * 64), 11'(192 + 32 * k),
                              12'((10 - k) * 64), 11'd0,
                              17'h1ABCD, 12'h123, 13'h1F0F, 12'hABC));
  endtask

  task automatic q_s2(input logic [7:0] cmd);
    fifo_q.push_back(mk_rec(cmd, 6'd3, 6'd9, 6'd30, 6'd5, 6'd5, 6'd5,
                            13'd64, 13'd64, 13'd64, 10'd7, 17'd1, 17'd2,
                            5'd1, 12'd1, 12'd1, 6'd1, 13'd1, 13'd1,
                            5'd1, 12'd1, 12'd1));
  endtask

  // Scenario 4: flat top, long edge runs past X_MAX, short edge below 0,
  // z/r/g overflow and b underflow from row 1.
  task automatic q_s4(input logic [7:0] cmd);
    fifo_q.push_back(mk_rec(cmd, 6'd60, 6'd2, 6'd0, 6'd0, 6'd0, 6'd6,
                            13'd128, 13'd0, 13'h1F80,
                            10'd1020, 17'd128, 17'h00001,
                            5'd31, 12'd64, 12'h000,
                            6'd63, 13'd64, 13'h0001,
                            5'd0, 12'hFFF, 12'h800));
    for (int k = 0; k < 6; k++)
      exp_q.push_back(mk_span(cmd, k == 5, 6'(k), 6'(s4_xl[k]), 6'(s4_xs[k]),
                              s4_z[k], s4_r[k], s4_g[k], 11'd0,
                              17'h00001, 12'h000, 13'h0001, 12'h800));
  endtask

  task automatic check(input string name, input logic [130:0] got, input logic [130:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && k < budget) begin
      @(negedge clk); #2; k++;
    end
    check("drain_timeout", 131'(exp_q.size() + fifo_q.size()), 131'd0);
    repeat (4) begin @(negedge clk); #2; end
  endtask

  task automatic wait_pushes(input int n, input int budget);
    int k = 0;
    while (push_cnt < n && k < budget) begin
      @(negedge clk); #2; k++;
    end
    check("push_wait", 131'(push_cnt), 131'(n));
  endtask

  // Show-ahead FIFO: pop happens after the edge that saw tri_pull high.
  initial begin
    logic         pend = 1'b0;
    logic [216:0] tmp;
    forever begin
      @(negedge clk);
      if (pend && fifo_q.size() > 0) tmp = fifo_q.pop_front();
      if (fifo_q.size() > 0) begin
        tri_empty = 1'b0;
        tri_data  = fifo_q[0];
      end else begin
        tri_empty = 1'b1;
      end
      #3;
      pend = tri_pull;
      if (tri_pull) pull_log.push_back(cyc);
    end
  end

  // Output monitor / scoreboard.
  initial begin
    logic [130:0] e;
    forever begin
      @(negedge clk);
      if (span_push === 1'b1) begin
        push_cnt++;
        if (span_data[122]) last_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          vec_cnt++;
          err_cnt++;
          $display("FAIL unexpected_span: got %h want no push", span_data);
        end else begin
          e = exp_q.pop_front();
          $display("span cmd=%h y=%0d xl=%0d xs=%0d z=%h last=%0d",
                   span_data[130:123], span_data[121:116], span_data[115:110],
                   span_data[109:104], span_data[103:88], span_data[122]);
          check("span", span_data, e);
        end
      end
    end
  end

  initial begin
    q_s1(8'h11);
    repeat (2) begin
      @(negedge clk); #2;
      check("rst_push", 131'(span_push), 131'd0);
      check("rst_data", span_data, 131'd0);
      check("rst_pull", 131'(tri_pull), 131'd0);
    end
    rst = 1'b1;
    wait_drain(100);
    check("s1_pulls", 131'(pull_log.size()), 131'd1);

    pull_log.delete();
    q_s2(8'h22);
    q_s1(8'h23);
    wait_drain(100);
    check("s2_pulls", 131'(pull_log.size()), 131'd2);
    if (pull_log.size() == 2)
      check("s2_spacing", 131'(pull_log[1] - pull_log[0]), 131'd2);

    push_cnt = 0;
    q_s1(8'h33);
    wait_pushes(3, 100);
    span_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      check("stall_push", 131'(span_push), 131'd0);
    end
    span_full = 1'b0;
    wait_drain(100);
    check("bp_total", 131'(push_cnt), 131'd8);

    q_s4(8'hA4);
    wait_drain(100);

    pull_log.delete();
    last_log.delete();
    q_s1(8'h55);
    q_s4(8'h66);
    wait_drain(200);
    check("b2b_pulls", 131'(pull_log.size()), 131'd2);
    if (pull_log.size() == 2 && last_log.size() > 0)
      check("b2b_gap", 131'(pull_log[1] - last_log[0]), 131'd1);

    push_cnt = 0;
    q_s1(8'h77);
    wait_pushes(4, 100);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk); #2;
    check("mid_rst_push", 131'(span_push), 131'd0);
    check("mid_rst_data", span_data, 131'd0);
    rst = 1'b1;
    repeat (6) begin @(negedge clk); #2; end
    check("mid_rst_nomore", 131'(push_cnt), 131'd4);
    pull_log.delete();
    q_s4(8'h88);
    wait_drain(100);
    check("mid_rst_repull", 131'(pull_log.size()), 131'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
